// File: rtl/ps_mem_pkg.sv
// Shared definitions for the ps_mem unified memory: FSM state encoding,
// grant selector and wait-counter width.
package ps_mem_pkg;

  // FSM state encodings
  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_WAIT = 2'd1;
  localparam logic [1:0] STATE_RESP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = STATE_IDLE,
    WAIT = STATE_WAIT,
    RESP = STATE_RESP
  } state_t;

  // Which port owns the access in flight
  typedef enum logic {
    GNT_IM = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

  // Wait-state counter width (RD_LAT 0..7)
  localparam int CNT_W = 3;

endpackage

// File: rtl/ps_mem_array.sv
// Backing word array for ps_mem_arbiter: one access write port, one preload
// write port (preload wins on a same-address collision) and registered
// read-out registers for the IM and DM ports. Addresses wrap modulo DEPTH.
module ps_mem_array
  import ps_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  rd_im,
  input  logic                  rd_dm,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_zero,
  output logic [DATA_WIDTH-1:0] im_r_data,
  output logic [DATA_WIDTH-1:0] dm_r_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      ld_idx;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Reduce an address to an array index (modulo DEPTH, works for any DEPTH)
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] t;
    t = 32'(a) % 32'(DEPTH);
    return t[IDX_W-1:0];
  endfunction

  assign wr_idx  = wrap_idx(wr_addr);
  assign ld_idx  = wrap_idx(ld_addr);
  assign rd_idx  = wrap_idx(rd_addr);
  assign rd_word = rd_zero ? '0 : mem[rd_idx];

  // Array writes; the later preload assignment overrides a same-index access write
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    if (ld_en) mem[ld_idx] <= ld_data;
  end

  // Per-port read registers; they hold until that port's next read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_r_data <= '0;
      dm_r_data <= '0;
    end else begin
      if (rd_im) im_r_data <= rd_word;
      if (rd_dm) dm_r_data <= rd_word;
    end
  end

endmodule

// File: rtl/ps_mem_arbiter.sv
// Unified IM/DM memory with programmable wait states and DM-priority
// arbitration bounded by a burst limit. Optional macro MEM_BOUNDS_CHECK_EN
// turns off address wrapping: out-of-range accesses are dropped and flagged
// on the sticky addr_err output.
//
// Handshake: a requester raises im_rd / dm_rd / dm_wr and holds it with
// stable operands until the matching one-cycle ready pulse. Requests are
// only sampled in IDLE; the access (array write or read-register update)
// commits on the edge that enters RESP, so r_data is valid while ready is high.
module ps_mem_arbiter
  import ps_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 256,
  parameter int RD_LAT       = 1,
  parameter int DM_BURST_MAX = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  im_rd,
  input  logic [ADDR_WIDTH-1:0] im_addr,
  output logic [DATA_WIDTH-1:0] im_r_data,
  output logic                  im_ready,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  output logic                  dm_ready,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  addr_err
);

  localparam int BURST_W = (DM_BURST_MAX < 1) ? 1 : $clog2(DM_BURST_MAX + 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  gnt_t                  gnt_q, gnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic dm_req;
  logic acc;
  logic acc_ok;
  logic ld_ok;

  assign dm_req = dm_rd | dm_wr;
  // The access commits on the edge that moves the FSM into RESP
  assign acc    = (state_d == RESP);

`ifdef MEM_BOUNDS_CHECK_EN
  logic addr_err_q;

  assign acc_ok   = (32'(addr_d) < 32'(DEPTH));
  assign ld_ok    = ld_en && (32'(ld_addr) < 32'(DEPTH));
  assign addr_err = addr_err_q;

  // Sticky out-of-range flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_err_q <= 1'b0;
    else if ((acc && !acc_ok) || (ld_en && !ld_ok)) addr_err_q <= 1'b1;
  end
`else
  assign acc_ok   = 1'b1;
  assign ld_ok    = ld_en;
  assign addr_err = 1'b0;
`endif

  // FSM state and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      burst_q <= '0;
      gnt_q   <= GNT_IM;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state, arbitration and request latching
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (dm_req || im_rd) begin
          // DM wins unless it has used up its burst allowance against a waiting IM
          if (dm_req && !(im_rd && (burst_q == BURST_W'(DM_BURST_MAX)))) begin
            gnt_d   = GNT_DM;
            wr_d    = dm_wr;
            addr_d  = dm_addr;
            wdata_d = dm_w_data;
            if (im_rd) burst_d = burst_q + 1'b1;
          end else begin
            gnt_d   = GNT_IM;
            wr_d    = 1'b0;
            addr_d  = im_addr;
            wdata_d = '0;
            burst_d = '0;
          end
          cnt_d   = CNT_W'(RD_LAT);
          state_d = (RD_LAT == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign im_ready = (state_q == RESP) && (gnt_q == GNT_IM);
  assign dm_ready = (state_q == RESP) && (gnt_q == GNT_DM);

  ps_mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (acc && wr_d && acc_ok),
    .wr_addr  (addr_d),
    .wr_data  (wdata_d),
    .ld_en    (ld_ok),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rd_im    (acc && !wr_d && (gnt_d == GNT_IM)),
    .rd_dm    (acc && !wr_d && (gnt_d == GNT_DM)),
    .rd_addr  (addr_d),
    .rd_zero  (!acc_ok),
    .im_r_data(im_r_data),
    .dm_r_data(dm_r_data)
  );

endmodule

// File: doc/ps_mem_arbiter.md
Name: ps_mem_arbiter

Overview:
Parametrised unified memory for the pipelined processor system. A single backing array serves two request ports: an instruction-fetch port (IM) and a data load/store port (DM). Accesses complete after a programmable number of wait states and are signalled with a ready pulse. A bench preload port fills the array before `start`.

Parameters:
ADDR_WIDTH, 8, address bits on every port
DATA_WIDTH, 16, word width
DEPTH, 256, number of array words (DEPTH <= 2**ADDR_WIDTH)
RD_LAT, 1, wait states per access (0..7)
DM_BURST_MAX, 2, consecutive DM grants allowed while an IM request is pending

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
im_rd  in  1  IM read request, level, held until im_ready
im_addr  in  ADDR_WIDTH  IM word address
im_r_data  out  DATA_WIDTH  IM read data
im_ready  out  1  one-cycle IM completion pulse
dm_rd  in  1  DM read request, level
dm_wr  in  1  DM write request, level
dm_addr  in  ADDR_WIDTH  DM word address
dm_w_data  in  DATA_WIDTH  DM write data
dm_r_data  out  DATA_WIDTH  DM read data
dm_ready  out  1  one-cycle DM completion pulse
ld_en  in  1  preload write strobe
ld_addr  in  ADDR_WIDTH  preload address
ld_data  in  DATA_WIDTH  preload data
addr_err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE. im_ready, dm_ready and addr_err are 0. im_r_data and dm_r_data are 0. Wait counter and DM-burst counter are 0. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a clock edge with any request, grant one port, latch its addr, wdata and op, and load the counter with RD_LAT.
  - If RD_LAT=0, go to RESP; otherwise go to WAIT.
  - With no request, stay in IDLE.
- WAIT: decrement the counter each cycle; go to RESP when the counter reaches 0.
- RESP: perform the array access on this cycle's edge.
  - Reads update the granted port's r_data register.
  - Writes update the array.
  - The granted port's ready is high for exactly this one cycle. Next state is IDLE.
- Latency: a request sampled at edge t0 produces ready during cycle t0+1+RD_LAT; r_data is valid from that cycle on.
- r_data holds its value until that port's next read completes. Writes do not change dm_r_data.
- Requester protocol:
  - Requester holds the request and operands stable until it sees ready.
  - A request still high in the IDLE cycle after ready is a new access.
  - Requests are not sampled in WAIT or RESP; changes there are ignored.
- Arbitration:
  - DM has priority over IM.
  - The burst counter increments on each DM grant made while im_rd=1, and clears on any IM grant.
  - When the counter equals DM_BURST_MAX and im_rd=1, IM wins the next grant.
- dm_rd and dm_wr both high: treated as a write only; dm_ready pulses once.
- Preload: ld_en writes the array on any edge, independent of the FSM.
  - If a DM write commits to the same address on the same edge, ld_data wins.
  - A read in RESP of the same address on the same edge returns the old array word.
- Address wrap: the address is used modulo DEPTH unless MEM_BOUNDS_CHECK_EN is defined.
- Reset mid-access: the access is abandoned, no write occurs, and no ready is issued.

Optional Feature:
Macro MEM_BOUNDS_CHECK_EN.
- Defined: an access with address >= DEPTH in RESP does not touch the array. A read returns all-zero data, ready still pulses, and addr_err sets and stays set until reset. Preload to an out-of-range address is dropped and sets addr_err.
- Undefined: addresses wrap modulo DEPTH and addr_err is tied 0.

Decomposition:
- Shared package ps_mem_pkg holds:
  - state encoding localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2)
  - the grant enum (GNT_IM, GNT_DM)
  - the wait-counter width constant (3 bits)
- One natural sub-module, ps_mem_array: a synchronous single-write-port array with a preload write port, ld priority on collision, and a registered read-out.
- FSM and arbitration remain in ps_mem_arbiter.

Test Plan:
- Preload word[5]=16'h00A0 via ld_en, RD_LAT=1, pulse im_rd addr 5 at t0 -> im_ready high during t0+2, im_r_data=16'h00A0, dm_ready stays 0.
- DM write addr 3 data 16'd160, then DM read addr 3 -> dm_r_data=16'd160; dm_r_data unchanged after the write's dm_ready.
- im_rd and dm_rd both held continuously, DM_BURST_MAX=2 -> grant order DM, DM, IM, DM, DM, IM; each ready is exactly one cycle wide.
- RD_LAT=0 versus RD_LAT=7 on the same read -> ready at t0+1 and t0+8 respectively.
- Write 16'hFFF6 (-10) to addr 4, deassert rst_n during the WAIT of a later write of 16'h1234 to addr 4 -> outputs 0, word[4] still 16'hFFF6, no ready.
- With MEM_BOUNDS_CHECK_EN, DEPTH=25, read addr 30 -> dm_r_data=0, dm_ready pulses, addr_err=1 and held; without the macro, the same read returns word[5].
